// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, mult/div interlock and a saturating stall-bubble counter.
module hazard_controller #(
  parameter int MD_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_usesRt,
  input  logic        ID_isMD,
  input  logic        ID_readsHiLo,
  input  logic [1:0]  EX_MemRead,
  input  logic [4:0]  EX_writeRegister,
  input  logic        EX_branchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MD_start,
  output logic        MD_busy,
  output logic [15:0] stallCycles
);

  localparam int CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] CountLoad = CW'(MD_LATENCY - 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  md_count_q, md_count_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;
  logic           lu_hazard;
  logic           md_hazard;
  logic           stall;

  assign MD_busy     = (state_q == ST_MD_BUSY);
  assign stallCycles = stall_cnt_q;

  assign lu_hazard = (EX_MemRead != 2'b00) && (EX_writeRegister != 5'd0) &&
                     ((EX_writeRegister == ID_rs) ||
                      (ID_usesRt && (EX_writeRegister == ID_rt)));
  assign md_hazard = MD_busy && (ID_isMD || ID_readsHiLo);
  // A taken branch squashes the ID instruction, so its hazards are irrelevant.
  assign stall     = (lu_hazard || md_hazard) && !EX_branchTaken;

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    MD_start    = 1'b0;
    if (Reset) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (EX_branchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else begin
      MD_start = ID_isMD && (state_q == ST_RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    md_count_d  = md_count_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (MD_start) begin
          state_d    = ST_MD_BUSY;
          md_count_d = CountLoad;
        end else begin
          state_d = ST_RUN;
        end
      end
      // Branches never abort the unit: the mult/div is older and architectural.
      ST_MD_BUSY: begin
        if (md_count_q != '0) begin
          md_count_d = md_count_q - CW'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        md_count_d = '0;
      end
    endcase
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      md_count_q  <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_count_q  <= md_count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
